// File: rtl/uart_key_rx.sv
// UART receiver for terminal keystrokes (8N1; 8E1 when UART_PARITY_EN is defined).
// Each good byte appears on key for KEY_HOLD cycles, flagged by a one-cycle key_valid strobe.
module uart_key_rx #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter int unsigned KEY_HOLD     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HW = $clog2(KEY_HOLD + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BREAK  = 3'd4;
`ifdef UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    logic          rx_m, rx_s;
    logic [2:0]    state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [HW-1:0] hold_cnt;
    logic          load_c, err_c;
`ifdef UART_PARITY_EN
    logic          par_bad, par_bad_n;
`endif

    // Two-flop synchronizer, idle-high reset so no false start follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
`ifdef UART_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        load_c    = 1'b0;
        err_c     = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_n = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n   = START;
                    clk_cnt_n = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_END) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n = '0;
                    par_bad_n = (^shreg) ^ rx_s;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
`endif
            STOP: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_n = '0;
`ifdef UART_PARITY_EN
                    // Bad parity and bad stop together still give a single error pulse.
                    load_c = rx_s && !par_bad;
                    err_c  = !rx_s || par_bad;
`else
                    load_c = rx_s;
                    err_c  = !rx_s;
`endif
                    state_n = rx_s ? IDLE : BREAK;
                end else begin
                    clk_cnt_n = clk_cnt + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output register and hold timer; a new byte always restarts the hold window.
    always_ff @(posedge clk) begin
        if (rst) begin
            key       <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            key_valid <= load_c;
            frame_err <= err_c;
            if (load_c) begin
                key      <= shreg;
                hold_cnt <= HW'(KEY_HOLD - 1);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end else begin
                key <= '0;
            end
        end
    end
endmodule
